// File: rtl/design_mux_pkg.sv
// design_mux_pkg
// Shared types and defaults for the design-select controller that sits in
// front of the Caravel mprj_io pads.
//   state_t  : controller sequencing states
//   DEF_*    : default parameter values used by design_mux_ctrl
//   one_hot  : one-hot encoding of an index (up to 32 entries)
// Optional feature macro used by the slice: DESIGN_MUX_REG_OUT_EN.

package design_mux_pkg;

    typedef enum logic [1:0] {
        ACTIVE     = 2'd0,
        DRAIN      = 2'd1,
        RESET_HOLD = 2'd2
    } state_t;

    localparam int DEF_NDES          = 4;
    localparam int DEF_IO_W          = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_RESET_CYCLES  = 8;
    localparam int DEF_DEFAULT_SEL   = 0;

    // Callers size the result down to their own design count with a cast.
    function automatic logic [31:0] one_hot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/design_mux_slice.sv
// design_mux_slice
// IO_W-wide NDES:1 selector for pad outputs and output enables, with a
// tristate override used while the controller is switching designs.
// Ports:
//   clk, rst           : clock and synchronous active-high reset (only used
//                        when the output register is built in)
//   sel                : index of the design to forward
//   tristate           : 1 forces io_oeb to all 1s and io_out to 0
//   des_io_out/oeb     : packed per-design buses, design d at [d*IO_W +: IO_W]
//   io_out, io_oeb     : selected pad output and active-low enable
// Macro DESIGN_MUX_REG_OUT_EN: when defined the outputs are registered
// (one cycle of latency, reset to the tristated value).

module design_mux_slice #(
    parameter int NDES  = 4,
    parameter int IO_W  = 16,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 tristate,
    input  logic [NDES*IO_W-1:0] des_io_out,
    input  logic [NDES*IO_W-1:0] des_io_oeb,
    output logic [IO_W-1:0]      io_out,
    output logic [IO_W-1:0]      io_oeb
);

    logic [IO_W-1:0] mux_out;
    logic [IO_W-1:0] mux_oeb;

    // Pick the selected design's slice; an out-of-range index or an active
    // tristate request leaves the pads as inputs driving zero.
    always_comb begin
        mux_out = '0;
        mux_oeb = '1;
        if (!tristate) begin
            for (int d = 0; d < NDES; d++) begin
                if (sel == SEL_W'(d)) begin
                    mux_out = des_io_out[d*IO_W +: IO_W];
                    mux_oeb = des_io_oeb[d*IO_W +: IO_W];
                end
            end
        end
    end

`ifdef DESIGN_MUX_REG_OUT_EN
    // Registered pad path: the tristate on a switch reaches the pads one
    // cycle after the controller leaves ACTIVE, as does the new design.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_out <= '0;
            io_oeb <= '1;
        end else begin
            io_out <= mux_out;
            io_oeb <= mux_oeb;
        end
    end
`else
    // Purely combinational forwarding; clock and reset are not needed.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    always_comb begin
        io_out = mux_out;
        io_oeb = mux_oeb;
    end
`endif

endmodule

// File: rtl/design_mux_ctrl.sv
// design_mux_ctrl
// Chooses which of NDES sub-designs drives the shared user IO. A switch
// tristates the pads (DRAIN), holds the new design in reset (RESET_HOLD)
// and then forwards its pads (ACTIVE).
// Ports:
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   sel_req, sel_valid     : requested design index and its one-cycle strobe
//   force_reset            : strobe, re-runs the reset hold on the current design
//   des_io_out, des_io_oeb : per-design pad outputs / active-low enables
//   io_out, io_oeb         : to the mprj_io pads
//   des_reset, des_ena     : per-design reset (active-high) and enable
//   active_sel             : index of the current design
//   busy                   : high while not in ACTIVE
//   bad_sel                : sticky flag for an out-of-range request
// Macro DESIGN_MUX_REG_OUT_EN (in design_mux_slice): registered pad outputs.

module design_mux_ctrl
    import design_mux_pkg::*;
#(
    parameter int NDES          = DEF_NDES,
    parameter int IO_W          = DEF_IO_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int DEFAULT_SEL   = DEF_DEFAULT_SEL,
    localparam int SEL_W        = $clog2(NDES)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [SEL_W-1:0]     sel_req,
    input  logic                 sel_valid,
    input  logic                 force_reset,
    input  logic [NDES*IO_W-1:0] des_io_out,
    input  logic [NDES*IO_W-1:0] des_io_oeb,
    output logic [IO_W-1:0]      io_out,
    output logic [IO_W-1:0]      io_oeb,
    output logic [NDES-1:0]      des_reset,
    output logic [NDES-1:0]      des_ena,
    output logic [SEL_W-1:0]     active_sel,
    output logic                 busy,
    output logic                 bad_sel
);

    localparam int MAX_CYC = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [SEL_W-1:0] pending, pending_next;
    logic             queued, queued_next;
    logic [SEL_W-1:0] active_next;
    logic             bad_next;
    logic             req_ok;
    logic             req_bad;
    logic             tristate;
    logic [NDES-1:0]  active_onehot;

    // State register: every piece of controller state lives here so that a
    // reset anywhere in a switch sequence discards pending and queued work.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= RESET_HOLD;
            cnt        <= '0;
            pending    <= '0;
            queued     <= 1'b0;
            active_sel <= SEL_W'(DEFAULT_SEL);
            bad_sel    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pending    <= pending_next;
            queued     <= queued_next;
            active_sel <= active_next;
            bad_sel    <= bad_next;
        end
    end

    // Next-state logic. A request is only "ok" when it names an existing
    // design. In ACTIVE a fresh differing request beats both a queued one
    // and force_reset. DRAIN requests overwrite the pending target; those
    // in RESET_HOLD go into a one-deep queue that fires on the first
    // ACTIVE cycle. The counter restarts on every state change and
    // saturates rather than wrapping.
    always_comb begin
        req_ok       = sel_valid && (32'(sel_req) < NDES);
        req_bad      = sel_valid && !(32'(sel_req) < NDES);
        state_next   = state;
        pending_next = pending;
        queued_next  = queued;
        active_next  = active_sel;
        bad_next     = bad_sel | req_bad;

        case (state)
            ACTIVE: begin
                if (req_ok && (sel_req != active_sel)) begin
                    pending_next = sel_req;
                    queued_next  = 1'b0;
                    state_next   = DRAIN;
                end else if (queued) begin
                    queued_next = 1'b0;
                    state_next  = DRAIN;
                end else if (force_reset) begin
                    state_next = RESET_HOLD;
                end
            end
            DRAIN: begin
                if (req_ok) begin
                    pending_next = sel_req;
                end
                if (cnt == SETTLE_LAST) begin
                    active_next = pending_next;
                    state_next  = RESET_HOLD;
                end
            end
            RESET_HOLD: begin
                if (req_ok && (sel_req != active_sel)) begin
                    pending_next = sel_req;
                    queued_next  = 1'b1;
                end
                if (cnt == RESET_LAST) begin
                    state_next = ACTIVE;
                end
            end
            default: begin
                state_next = RESET_HOLD;
            end
        endcase

        if (state_next != state) begin
            cnt_next = '0;
        end else if (cnt != '1) begin
            cnt_next = cnt + 1'b1;
        end else begin
            cnt_next = cnt;
        end
    end

    // Output decode: only ACTIVE releases a design's reset and lets its pads
    // through; DRAIN also drops every enable so the outgoing design is idle.
    always_comb begin
        active_onehot = NDES'(one_hot(32'(active_sel)));
        tristate      = (state != ACTIVE);
        busy          = (state != ACTIVE);
        des_reset     = '1;
        des_ena       = active_onehot;
        case (state)
            ACTIVE:     des_reset = ~active_onehot;
            DRAIN:      des_ena   = '0;
            RESET_HOLD: des_ena   = active_onehot;
            default:    des_ena   = '0;
        endcase
    end

    design_mux_slice #(
        .NDES  (NDES),
        .IO_W  (IO_W),
        .SEL_W (SEL_W)
    ) u_slice (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .sel        (active_sel),
        .tristate   (tristate),
        .des_io_out (des_io_out),
        .des_io_oeb (des_io_oeb),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

endmodule

// File: tb/tb_design_mux_ctrl.sv
// tb_design_mux_ctrl
// Directed bench for design_mux_ctrl. A second instance with NDES=3 covers
// the out-of-range request, which cannot be expressed on a 2-bit sel_req
// when NDES=4. Honours DESIGN_MUX_REG_OUT_EN for the pad latency.

module tb_design_mux_ctrl;

`ifdef DESIGN_MUX_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [1:0]  sel_req = '0;
    logic        sel_valid = 1'b0;
    logic        force_reset = 1'b0;
    logic [63:0] des_io_out;
    logic [63:0] des_io_oeb;
    logic [15:0] io_out, io_oeb;
    logic [3:0]  des_reset, des_ena;
    logic [1:0]  active_sel;
    logic        busy, bad_sel;

    logic [1:0]  sel_req3 = '0;
    logic        sel_valid3 = 1'b0;
    logic        force_reset3 = 1'b0;
    logic [15:0] io_out3, io_oeb3;
    logic [2:0]  des_reset3, des_ena3;
    logic [1:0]  active_sel3;
    logic        busy3, bad_sel3;

    int vectors = 0;
    int miscompares = 0;

    // design 3..0 patterns: out C3C3/3C3C/5A5A/A5A5, oeb FF00/0F0F/00FF/0000
    assign des_io_out = 64'hC3C3_3C3C_5A5A_A5A5;
    assign des_io_oeb = 64'hFF00_0F0F_00FF_0000;

    always #5 wb_clk_i = ~wb_clk_i;

    design_mux_ctrl dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .sel_req     (sel_req),
        .sel_valid   (sel_valid),
        .force_reset (force_reset),
        .des_io_out  (des_io_out),
        .des_io_oeb  (des_io_oeb),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .des_reset   (des_reset),
        .des_ena     (des_ena),
        .active_sel  (active_sel),
        .busy        (busy),
        .bad_sel     (bad_sel)
    );

    design_mux_ctrl #(.NDES(3)) dut3 (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .sel_req     (sel_req3),
        .sel_valid   (sel_valid3),
        .force_reset (force_reset3),
        .des_io_out  (des_io_out[47:0]),
        .des_io_oeb  (des_io_oeb[47:0]),
        .io_out      (io_out3),
        .io_oeb      (io_oeb3),
        .des_reset   (des_reset3),
        .des_ena     (des_ena3),
        .active_sel  (active_sel3),
        .busy        (busy3),
        .bad_sel     (bad_sel3)
    );

    // Advance n clock edges; observations happen 1 ns after each edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold-phase check repeated over n cycles; counts each cycle as a vector.
    task automatic checkBusyFor(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(tag, 32'(busy), 32'h1);
            applyStimulus(1);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        applyStimulus(2);
        checkOutput("rst_busy",      32'(busy),       32'h1);
        checkOutput("rst_active",    32'(active_sel), 32'h0);
        checkOutput("rst_des_reset", 32'(des_reset),  32'hF);
        checkOutput("rst_des_ena",   32'(des_ena),    32'h1);
        checkOutput("rst_io_oeb",    32'(io_oeb),     32'hFFFF);
        checkOutput("rst_io_out",    32'(io_out),     32'h0);
        checkOutput("rst_bad_sel",   32'(bad_sel),    32'h0);
        wb_rst_i = 1'b0;

        // Reset hold: 8 cycles busy including the one already observed
        checkBusyFor("hold_busy", 7);
        checkOutput("hold_last_ena", 32'(des_ena),   32'h1);
        applyStimulus(1);
        checkOutput("act0_busy",      32'(busy),      32'h0);
        checkOutput("act0_des_reset", 32'(des_reset), 32'hE);
        checkOutput("act0_io_out",    32'(io_out),    REG_OUT ? 32'h0 : 32'hA5A5);
        checkOutput("act0_io_oeb",    32'(io_oeb),    REG_OUT ? 32'hFFFF : 32'h0000);
        applyStimulus(1);
        checkOutput("act0_io_out_settled", 32'(io_out), 32'hA5A5);

        // Switch to design 2
        sel_req = 2'd2; sel_valid = 1'b1;
        applyStimulus(1);
        sel_valid = 1'b0;
        checkOutput("drain_busy",   32'(busy),       32'h1);
        checkOutput("drain_ena",    32'(des_ena),    32'h0);
        checkOutput("drain_reset",  32'(des_reset),  32'hF);
        checkOutput("drain_io_oeb", 32'(io_oeb),     REG_OUT ? 32'h0000 : 32'hFFFF);
        checkOutput("drain_active", 32'(active_sel), 32'h0);
        applyStimulus(3);
        checkOutput("drain_last_ena", 32'(des_ena), 32'h0);
        applyStimulus(1);
        checkOutput("hold2_ena",    32'(des_ena),    32'h4);
        checkOutput("hold2_active", 32'(active_sel), 32'h2);
        checkOutput("hold2_io_oeb", 32'(io_oeb),     32'hFFFF);
        applyStimulus(7);
        checkOutput("hold2_last_busy", 32'(busy), 32'h1);
        applyStimulus(1);
        checkOutput("act2_busy",      32'(busy),      32'h0);
        checkOutput("act2_des_reset", 32'(des_reset), 32'hB);
        applyStimulus(1);
        checkOutput("act2_io_out", 32'(io_out), 32'h3C3C);
        checkOutput("act2_io_oeb", 32'(io_oeb), 32'h0F0F);

        // Same-index request is ignored
        sel_req = 2'd2; sel_valid = 1'b1;
        applyStimulus(1);
        sel_valid = 1'b0;
        checkOutput("same_sel_busy", 32'(busy), 32'h0);

        // Out-of-range request on the NDES=3 instance
        checkOutput("nd3_io_out", 32'(io_out3), 32'hA5A5);
        sel_req3 = 2'd3; sel_valid3 = 1'b1;
        applyStimulus(1);
        sel_valid3 = 1'b0;
        checkOutput("bad_sel_set",  32'(bad_sel3),    32'h1);
        checkOutput("bad_busy",     32'(busy3),       32'h0);
        checkOutput("bad_active",   32'(active_sel3), 32'h0);
        applyStimulus(2);
        checkOutput("bad_sel_sticky", 32'(bad_sel3), 32'h1);
        checkOutput("bad_io_out",     32'(io_out3),  32'hA5A5);
        checkOutput("main_bad_sel",   32'(bad_sel),  32'h0);

        // Request during DRAIN overwrites pending, request during hold queues
        sel_req = 2'd0; sel_valid = 1'b1;
        applyStimulus(1);
        sel_req = 2'd1;
        applyStimulus(1);
        sel_valid = 1'b0;
        applyStimulus(3);
        checkOutput("ovr_active", 32'(active_sel), 32'h1);
        checkOutput("ovr_ena",    32'(des_ena),    32'h2);
        sel_req = 2'd3; sel_valid = 1'b1;
        applyStimulus(1);
        sel_valid = 1'b0;
        applyStimulus(6);
        checkOutput("q_hold_busy", 32'(busy), 32'h1);
        applyStimulus(1);
        checkOutput("q_act_busy",   32'(busy),       32'h0);
        checkOutput("q_act_sel",    32'(active_sel), 32'h1);
        checkOutput("q_act_reset",  32'(des_reset),  32'hD);
        applyStimulus(1);
        checkOutput("q_drain_busy", 32'(busy),    32'h1);
        checkOutput("q_drain_ena",  32'(des_ena), 32'h0);
        applyStimulus(4);
        checkOutput("q_hold3_sel", 32'(active_sel), 32'h3);
        applyStimulus(8);
        checkOutput("q_act3_busy", 32'(busy),    32'h0);
        checkOutput("q_act3_ena",  32'(des_ena), 32'h8);
        applyStimulus(1);
        checkOutput("q_act3_io_out", 32'(io_out), 32'hC3C3);

        // force_reset skips DRAIN
        force_reset = 1'b1;
        applyStimulus(1);
        force_reset = 1'b0;
        checkOutput("frc_busy",   32'(busy),       32'h1);
        checkOutput("frc_reset",  32'(des_reset),  32'hF);
        checkOutput("frc_ena",    32'(des_ena),    32'h8);
        checkOutput("frc_active", 32'(active_sel), 32'h3);
        checkOutput("frc_io_oeb", 32'(io_oeb),     REG_OUT ? 32'hFF00 : 32'hFFFF);
        applyStimulus(7);
        checkOutput("frc_last_busy", 32'(busy), 32'h1);
        applyStimulus(1);
        checkOutput("frc_act_reset", 32'(des_reset), 32'h7);

        // sel_valid beats force_reset, then reset mid-DRAIN
        sel_req = 2'd2; sel_valid = 1'b1; force_reset = 1'b1;
        applyStimulus(1);
        sel_valid = 1'b0; force_reset = 1'b0;
        checkOutput("prio_ena", 32'(des_ena), 32'h0);
        applyStimulus(1);
        wb_rst_i = 1'b1;
        applyStimulus(1);
        wb_rst_i = 1'b0;
        checkOutput("midrst_active", 32'(active_sel), 32'h0);
        checkOutput("midrst_ena",    32'(des_ena),    32'h1);
        checkOutput("midrst_reset",  32'(des_reset),  32'hF);
        checkOutput("midrst_busy",   32'(busy),       32'h1);
        applyStimulus(8);
        checkOutput("midrst_act_busy", 32'(busy),       32'h0);
        checkOutput("midrst_act_sel",  32'(active_sel), 32'h0);
        applyStimulus(1);
        checkOutput("midrst_no_pending", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
